// File: rtl/sin_job_sequencer.sv
// sin_job_sequencer: front-end for the 8.8 fixed-point sine core.
// Accepts unsigned 8.8 angles, range-reduces them into [0, pi/2], launches
// the core, then applies the quadrant sign to the core result.
// Optional feature macro: SIN_SEQ_COS_EN adds the cos_sel input and turns
// the job into sin(x + pi/2).
//
// Handshake rules (both ports): a transfer happens on a rising clk edge
// where valid && ready are both high. in_ready is high only in IDLE and an
// in_valid seen outside IDLE is dropped. out_valid stays high with out_data
// held until out_ready is seen.
module sin_job_sequencer #(
  parameter int           PI_Q      = 804,
  parameter int           HALF_PI_Q = 402,
  parameter int           TWO_PI_Q  = 1608,
  parameter logic [7:0]   YIN_CONST = 8'h00,
  parameter int           TIMEOUT   = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_angle,
`ifdef SIN_SEQ_COS_EN
  input  logic        cos_sel,
`endif
  output logic        core_start,
  output logic [15:0] core_xin,
  output logic [7:0]  core_yin,
  input  logic [15:0] core_out,
  input  logic        core_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        err,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MOD   = 3'd1,
    ST_QUAD  = 3'd2,
    ST_START = 3'd3,
    ST_GUARD = 3'd4,
    ST_WAIT  = 3'd5,
    ST_OUT   = 3'd6
  } state_t;

  localparam logic [16:0] PI_W   = 17'(PI_Q);
  localparam logic [16:0] HALF_W = 17'(HALF_PI_Q);
  localparam logic [16:0] TWO_W  = 17'(TWO_PI_Q);
  localparam logic [6:0]  T_LAST = 7'(TIMEOUT - 1);

  state_t      state;
  logic [16:0] acc;
  logic        neg;
  logic [6:0]  timer;

  logic [16:0] load_val;
  logic [16:0] quad_sub;
  logic        quad_neg;
  logic [15:0] quad_xin;

  assign core_yin  = YIN_CONST;
  assign dbg_state = state;

  // Value loaded into the accumulator on accept (cosine adds a quarter turn).
  always_comb begin
    load_val = {1'b0, in_angle};
`ifdef SIN_SEQ_COS_EN
    if (cos_sel) load_val = {1'b0, in_angle} + HALF_W;
`endif
  end

  // Quadrant fold: drop a half turn (sets the sign), then reflect about pi/2.
  always_comb begin
    quad_neg = 1'b0;
    quad_sub = acc;
    if (acc >= PI_W) begin
      quad_sub = acc - PI_W;
      quad_neg = 1'b1;
    end
    quad_xin = 16'(quad_sub);
    if (quad_sub > HALF_W) quad_xin = 16'(PI_W - quad_sub);
  end

  // Job sequencer FSM with registered handshake and core-side outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      in_ready   <= 1'b1;
      core_start <= 1'b0;
      core_xin   <= 16'h0000;
      out_valid  <= 1'b0;
      out_data   <= 16'h0000;
      err        <= 1'b0;
      acc        <= 17'd0;
      neg        <= 1'b0;
      timer      <= 7'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            acc      <= load_val;
            neg      <= 1'b0;
            in_ready <= 1'b0;
            state    <= ST_MOD;
          end
        end
        ST_MOD: begin
          // One 2*pi subtraction per cycle keeps the datapath a single subtractor.
          if (acc >= TWO_W) acc <= acc - TWO_W;
          else              state <= ST_QUAD;
        end
        ST_QUAD: begin
          acc        <= {1'b0, quad_xin};
          neg        <= quad_neg;
          core_xin   <= quad_xin;
          core_start <= 1'b1;
          state      <= ST_START;
        end
        ST_START: begin
          core_start <= 1'b0;
          timer      <= 7'd0;
          state      <= ST_GUARD;
        end
        ST_GUARD: begin
          // core_ready may still be high from the previous job; skip it.
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (core_ready) begin
            out_data  <= neg ? 16'(16'h0000 - core_out) : core_out;
            out_valid <= 1'b1;
            state     <= ST_OUT;
          end else if (timer == T_LAST) begin
            err       <= 1'b1;
            out_data  <= 16'h0000;
            out_valid <= 1'b1;
            state     <= ST_OUT;
          end else begin
            timer <= timer + 7'd1;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          out_valid  <= 1'b0;
          core_start <= 1'b0;
          in_ready   <= 1'b1;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sin_job_sequencer.sv
// Testbench for sin_job_sequencer: random and directed angles, a core model
// echoing core_xin, a quadrant reference model and an output scoreboard.
module tb_sin_job_sequencer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_angle = 16'h0000;
`ifdef SIN_SEQ_COS_EN
  logic        cos_sel = 1'b0;
`endif
  logic        core_start;
  logic [15:0] core_xin;
  logic [7:0]  core_yin;
  logic [15:0] core_out = 16'h0000;
  logic        core_ready = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        err;
  logic [2:0]  dbg_state;

  sin_job_sequencer dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_angle(in_angle),
`ifdef SIN_SEQ_COS_EN
    .cos_sel(cos_sel),
`endif
    .core_start(core_start), .core_xin(core_xin), .core_yin(core_yin),
    .core_out(core_out), .core_ready(core_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .err(err), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [16:0] exp_q[$];   // {err, data}
  logic [15:0] xin_q[$];
  int checks = 0;
  int failures = 0;
  bit err_sticky = 1'b0;
  bit core_hang = 1'b0;
  int ready_mode = 0;      // 0: always ready, 1: random, 2: held low
  int core_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Reference: reduce by 2*pi with modulo, fold by quadrant, signed result.
  function automatic void ref_model(input int angle, input bit cs,
                                    output logic [15:0] xin, output logic [15:0] data);
    int a;
    bit n;
    a = (angle + (cs ? 402 : 0)) % 1608;
    n = (a >= 804);
    if (n) a = a - 804;
    if (a > 402) a = 804 - a;
    xin  = 16'(a);
    data = n ? 16'(0 - a) : 16'(a);
  endfunction

  // ---------------- core model ----------------
  always @(negedge clk) begin
    if (!rst) begin
      core_cnt = 0;
      core_ready = 1'b0;
    end else if (core_start) begin
      core_ready = 1'b0;
      core_out = core_xin;
      core_cnt = core_hang ? 0 : 5;
      check("xin_expected_pending", 32'(xin_q.size() > 0), 1);
      if (xin_q.size() > 0) check("core_xin", core_xin, xin_q.pop_front());
      check("core_yin", core_yin, 8'h00);
    end else if (core_cnt > 0) begin
      core_cnt--;
      if (core_cnt == 0) core_ready = 1'b1;
    end
  end

  // ---------------- downstream ready driver ----------------
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // ---------------- output monitor ----------------
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      check("out_expected_pending", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        logic [16:0] e;
        e = exp_q.pop_front();
        check("out_data", out_data, e[15:0]);
        check("out_err", err, e[16]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input int angle, input bit cs, input bit hang);
    logic [15:0] x;
    logic [15:0] d;
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_before_send", in_ready, 1);
    if (!in_ready) return;
    ref_model(angle, cs, x, d);
    core_hang = hang;
    if (hang) begin
      d = 16'h0000;
      err_sticky = 1'b1;
    end
    xin_q.push_back(x);
    exp_q.push_back({err_sticky, d});
    in_valid = 1'b1;
    in_angle = 16'(angle);
`ifdef SIN_SEQ_COS_EN
    cos_sel = cs;
`endif
    @(negedge clk);
    in_valid = 1'b0;
    in_angle = 16'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain_done", 32'(exp_q.size()), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int dir[11];
    int n;
    int viol;
    logic [15:0] z;
    dir = '{200, 1004, 600, 1808, 0, 1608, 804, 402, 403, 1206, 65535};

    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_core_start", core_start, 0);
    check("rst_core_xin", core_xin, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_err", err, 0);
    check("rst_state_idle", dbg_state, 0);
    rst = 1'b1;

    // Directed boundary and quadrant angles.
    foreach (dir[i]) send(dir[i], 1'b0, 1'b0);
    drain();
    ref_model(1004, 1'b0, z, z);
    check("model_sanity_1004", z, 16'hFF38);

`ifdef SIN_SEQ_COS_EN
    send(0, 1'b1, 1'b0);
    send(804, 1'b1, 1'b0);
    send(65535, 1'b1, 1'b0);
    drain();
`endif

    // Random angles with random downstream backpressure.
    ready_mode = 1;
    for (int i = 0; i < 40; i++) begin
      int a;
      bit cs;
      a = (i % 4 == 0) ? int'($urandom_range(0, 1700)) : int'($urandom_range(0, 65535));
      cs = 1'b0;
`ifdef SIN_SEQ_COS_EN
      cs = 1'($urandom_range(0, 1));
`endif
      send(a, cs, 1'b0);
    end
    drain();

    // Held backpressure: output stable, busy input ignored.
    ready_mode = 2;
    send(200, 1'b0, 1'b0);
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("hold_out_valid_seen", out_valid, 1);
    in_valid = 1'b1;
    in_angle = 16'd777;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_out_valid", out_valid, 1);
      check("hold_out_data", out_data, 16'h00C8);
      check("hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    ready_mode = 0;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("release_in_ready", in_ready, 1);
    check("release_state_idle", dbg_state, 0);
    check("release_out_valid", out_valid, 0);
    drain();

    // Core never responds: timeout result and sticky err.
    send(300, 1'b0, 1'b1);
    drain();
    check("err_sticky", err, 1);
    send(100, 1'b0, 1'b0);
    drain();

    // Reset in the middle of WAIT.
    send(500, 1'b0, 1'b1);
    n = 0;
    while (dbg_state != 3'd5 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("reached_wait", dbg_state, 3'd5);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("arst_in_ready", in_ready, 1);
    check("arst_core_start", core_start, 0);
    check("arst_core_xin", core_xin, 0);
    check("arst_out_valid", out_valid, 0);
    check("arst_out_data", out_data, 0);
    check("arst_err", err, 0);
    exp_q.delete();
    xin_q.delete();
    err_sticky = 1'b0;
    core_hang = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (core_start || out_valid) viol++;
    end
    check("quiet_after_reset", viol, 0);
    send(1808, 1'b0, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished t=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
